muxn_stream: RTL

Parametrised N-input streaming multiplexer: generalises the two-input combinational select to NUM_IN channels of WIDTH bits with valid/ready handshakes, packet locking on a `last` flag, selectable static or round-robin channel choice, and one registered output stage. Sits between the global-buffer read ports and the PE-array feeder, replacing fixed two-way buffer selects where several sources share one datapath.

---
 rtl/accel_pkg.sv | 9 +
 rtl/rr_pick.sv | 23 ++
 rtl/muxn_stream.sv | 112 +++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator stream-routing blocks.
package accel_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {IDLE, LOCKED} state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  always_comb begin
    gnt_idx = '0;
    gnt_any = |req;
    // Walk from farthest to nearest so the closest request to ptr is written last.
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (req[SEL_W'((int'(ptr) + k) % NUM_IN)]) begin
        gnt_idx = SEL_W'((int'(ptr) + k) % NUM_IN);
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-input valid/ready stream mux with packet locking, static or round-robin
// channel choice, and a single registered output stage.
//
// state  | meaning
// IDLE   | between packets; grant from sel (static) or rr_pick (round-robin)
// LOCKED | mid-packet; grant pinned to lock_ch until a beat with last
module muxn_stream
  import accel_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, rr_ptr_q;
  logic [SEL_W-1:0]  grant, rr_idx;
  logic              grant_ok, rr_any;
  logic              can_load, in_xfer, sel_last;
  logic [WIDTH-1:0]  sel_data;

  rr_pick #(.NUM_IN(NUM_IN)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign can_load = ~out_valid | out_ready;

  // sel may exceed NUM_IN-1 when NUM_IN is not a power of two; then nobody is ready.
  always_comb begin
    grant    = sel;
    grant_ok = (int'(sel) < NUM_IN);
    if (state_q == LOCKED) begin
      grant    = lock_ch_q;
      grant_ok = 1'b1;
    end else if (mode == MODE_RR) begin
      grant    = rr_idx;
      grant_ok = rr_any;
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = can_load & grant_ok;
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_last    = in_last[i];
      end
    end
  end

  assign in_xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_xfer && !sel_last) state_d = LOCKED;
      LOCKED: if (in_xfer &&  sel_last) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else if (in_xfer) begin
      if (state_q == IDLE && !sel_last) lock_ch_q <= grant;
      if (sel_last) rr_ptr_q <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
